// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: FSM states,
// instruction classes, opcode/funct fields, ALU codes and mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_I    = 4'd2,
        EXEC_R    = 4'd3,
        EXEC_LUI  = 4'd4,
        WB_ALU    = 4'd5,
        MEM_ADDR  = 4'd6,
        MEM_RD    = 4'd7,
        WB_MEM    = 4'd8,
        MEM_WR    = 4'd9,
        BRANCH    = 4'd10,
        JAL       = 4'd11,
        JALR_ADDR = 4'd12,
        JALR_LINK = 4'd13,
        TRAP      = 4'd14
    } state_e;

    typedef enum logic [3:0] {
        CLS_ADDI    = 4'd0,
        CLS_SLL     = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_LBU     = 4'd3,
        CLS_SB      = 4'd4,
        CLS_BNE     = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_e;

    // Opcodes
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct3 / funct7 values of the supported instructions
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [6:0] F7_ZERO = 7'b0000000;

    // ALU control codes
    localparam logic [2:0] ALU_ADD      = 3'b000;
    localparam logic [2:0] ALU_NE       = 3'b001;
    localparam logic [2:0] ALU_JAL_ADD  = 3'b010;
    localparam logic [2:0] ALU_JALR_ADD = 3'b011;
    localparam logic [2:0] ALU_LUI      = 3'b100;
    localparam logic [2:0] ALU_LBU      = 3'b101;
    localparam logic [2:0] ALU_SB_ADD   = 3'b110;
    localparam logic [2:0] ALU_SLL      = 3'b111;

    // Operand A select
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    // Operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Immediate format
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Register-file write-back source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Complete set of control outputs, so reset gating is a single mux
    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm;
        logic [1:0] result;
        logic       pc_src;
        logic       addr_src;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
    } ctrl_t;

    // Immediate format that the instruction class uses in DECODE
    function automatic logic [2:0] imm_for_class(input instr_class_e cls);
        logic [2:0] imm;
        case (cls)
            CLS_SB:  imm = IMM_S;
            CLS_BNE: imm = IMM_B;
            CLS_JAL: imm = IMM_J;
            CLS_LUI: imm = IMM_U;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational classifier: maps an instruction word onto one of the
// supported instruction classes and flags anything else as illegal.
module instr_class_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr,
    output instr_class_e          cls,
    output logic                  legal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       unused_fields_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    // Register and immediate fields are irrelevant to classification
    assign unused_fields_s = ^{instr[24:15], instr[11:7]};

    // Opcode/funct match to instruction class
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode_s)
            OP_IMM:    if (funct3_s == F3_ADDI) cls = CLS_ADDI; else cls = CLS_ILLEGAL;
            OP_REG:    if ((funct3_s == F3_SLL) && (funct7_s == F7_ZERO)) cls = CLS_SLL;
                       else cls = CLS_ILLEGAL;
            OP_LUI:    cls = CLS_LUI;
            OP_LOAD:   if (funct3_s == F3_LBU) cls = CLS_LBU; else cls = CLS_ILLEGAL;
            OP_STORE:  if (funct3_s == F3_SB) cls = CLS_SB; else cls = CLS_ILLEGAL;
            OP_BRANCH: if (funct3_s == F3_BNE) cls = CLS_BNE; else cls = CLS_ILLEGAL;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   if (funct3_s == F3_JALR) cls = CLS_JALR; else cls = CLS_ILLEGAL;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32 ALU subset. Moore outputs decoded
// from the state register, except the fetch write strobes (qualified by
// mem_ready) and the branch PC write (qualified by the ALU Zero flag).
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic                      zero,
    input  logic                      mem_ready,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control,
    output logic [1:0]                src_a_sel,
    output logic [1:0]                src_b_sel,
    output logic [2:0]                imm_src,
    output logic [1:0]                result_src,
    output logic                      pc_src,
    output logic                      addr_src,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic                      reg_write,
    output logic                      illegal_instr,
    output logic [3:0]                state_dbg
);

    state_e       state_q, state_d;
    logic         illegal_q, illegal_d;
    instr_class_e cls_s;
    logic         legal_s;
    ctrl_t        ctrl_s;
    ctrl_t        ctrl_out_s;

    instr_class_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr (instr),
        .cls   (cls_s),
        .legal (legal_s)
    );

    // State and sticky illegal flag; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE; else state_d = FETCH;
            DECODE: begin
                if (!legal_s) begin
                    state_d = TRAP;
                end else begin
                    case (cls_s)
                        CLS_ADDI: state_d = EXEC_I;
                        CLS_SLL:  state_d = EXEC_R;
                        CLS_LUI:  state_d = EXEC_LUI;
                        CLS_LBU:  state_d = MEM_ADDR;
                        CLS_SB:   state_d = MEM_ADDR;
                        CLS_BNE:  state_d = BRANCH;
                        CLS_JAL:  state_d = JAL;
                        CLS_JALR: state_d = JALR_ADDR;
                        default:  state_d = TRAP;
                    endcase
                end
            end
            EXEC_I:    state_d = WB_ALU;
            EXEC_R:    state_d = WB_ALU;
            EXEC_LUI:  state_d = WB_ALU;
            WB_ALU:    state_d = FETCH;
            MEM_ADDR: begin
                if (cls_s == CLS_LBU) state_d = MEM_RD;
                else if (cls_s == CLS_SB) state_d = MEM_WR;
                else state_d = TRAP;
            end
            MEM_RD:    if (mem_ready) state_d = WB_MEM; else state_d = MEM_RD;
            WB_MEM:    state_d = FETCH;
            MEM_WR:    if (mem_ready) state_d = FETCH; else state_d = MEM_WR;
            BRANCH:    state_d = FETCH;
            JAL:       state_d = FETCH;
            JALR_ADDR: state_d = JALR_LINK;
            JALR_LINK: state_d = FETCH;
            TRAP:      state_d = TRAP;
            default:   state_d = TRAP;
        endcase
    end

    // Illegal flag is set on the way into TRAP and only reset clears it
    always_comb begin
        illegal_d = illegal_q;
        if (state_d == TRAP) illegal_d = 1'b1;
        else illegal_d = illegal_q;
    end

    // Per-state control decode
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            FETCH: begin
                ctrl_s.mem_req  = 1'b1;
                ctrl_s.addr_src = 1'b0;
                ctrl_s.src_a    = SRC_A_PC;
                ctrl_s.src_b    = SRC_B_FOUR;
                ctrl_s.alu      = ALU_ADD;
                ctrl_s.pc_src   = 1'b0;
                ctrl_s.ir_write = mem_ready;
                ctrl_s.pc_write = mem_ready;
            end
            DECODE: begin
                // ALUOut captures oldPC + imm as branch/jump target
                ctrl_s.src_a = SRC_A_OLD_PC;
                ctrl_s.src_b = SRC_B_IMM;
                ctrl_s.alu   = ALU_ADD;
                ctrl_s.imm   = imm_for_class(cls_s);
            end
            EXEC_I: begin
                ctrl_s.src_a = SRC_A_RS1;
                ctrl_s.src_b = SRC_B_IMM;
                ctrl_s.imm   = IMM_I;
                ctrl_s.alu   = ALU_ADD;
            end
            EXEC_R: begin
                ctrl_s.src_a = SRC_A_RS1;
                ctrl_s.src_b = SRC_B_RS2;
                ctrl_s.alu   = ALU_SLL;
            end
            EXEC_LUI: begin
                ctrl_s.src_b = SRC_B_IMM;
                ctrl_s.imm   = IMM_U;
                ctrl_s.alu   = ALU_LUI;
            end
            WB_ALU: begin
                ctrl_s.result    = RES_ALUOUT;
                ctrl_s.reg_write = 1'b1;
            end
            MEM_ADDR: begin
                ctrl_s.src_a = SRC_A_RS1;
                ctrl_s.src_b = SRC_B_IMM;
                ctrl_s.alu   = ALU_ADD;
                if (cls_s == CLS_SB) ctrl_s.imm = IMM_S; else ctrl_s.imm = IMM_I;
            end
            MEM_RD: begin
                ctrl_s.mem_req  = 1'b1;
                ctrl_s.addr_src = 1'b1;
                ctrl_s.mem_we   = 1'b0;
            end
            WB_MEM: begin
                ctrl_s.result    = RES_MEM;
                ctrl_s.alu       = ALU_LBU;
                ctrl_s.reg_write = 1'b1;
            end
            MEM_WR: begin
                ctrl_s.mem_req  = 1'b1;
                ctrl_s.mem_we   = 1'b1;
                ctrl_s.addr_src = 1'b1;
                ctrl_s.alu      = ALU_SB_ADD;
            end
            BRANCH: begin
                // Zero=0 means operands differ, so BNE is taken
                ctrl_s.src_a    = SRC_A_RS1;
                ctrl_s.src_b    = SRC_B_RS2;
                ctrl_s.alu      = ALU_NE;
                ctrl_s.pc_src   = 1'b1;
                ctrl_s.pc_write = ~zero;
            end
            JAL, JALR_LINK: begin
                // Link value oldPC + 4 goes straight to rd; PC takes ALUOut
                ctrl_s.src_a     = SRC_A_OLD_PC;
                ctrl_s.src_b     = SRC_B_FOUR;
                ctrl_s.alu       = ALU_JAL_ADD;
                ctrl_s.result    = RES_ALU;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.pc_src    = 1'b1;
                ctrl_s.pc_write  = 1'b1;
            end
            JALR_ADDR: begin
                ctrl_s.src_a = SRC_A_RS1;
                ctrl_s.src_b = SRC_B_IMM;
                ctrl_s.imm   = IMM_I;
                ctrl_s.alu   = ALU_JALR_ADD;
            end
            TRAP:    ctrl_s = '0;
            default: ctrl_s = '0;
        endcase
    end

    // While reset is asserted every strobe and select is forced low at once
    assign ctrl_out_s = rst_n ? ctrl_s : '0;

    assign alu_control   = ctrl_out_s.alu;
    assign src_a_sel     = ctrl_out_s.src_a;
    assign src_b_sel     = ctrl_out_s.src_b;
    assign imm_src       = ctrl_out_s.imm;
    assign result_src    = ctrl_out_s.result;
    assign pc_src        = ctrl_out_s.pc_src;
    assign addr_src      = ctrl_out_s.addr_src;
    assign mem_req       = ctrl_out_s.mem_req;
    assign mem_we        = ctrl_out_s.mem_we;
    assign ir_write      = ctrl_out_s.ir_write;
    assign pc_write      = ctrl_out_s.pc_write;
    assign reg_write     = ctrl_out_s.reg_write;
    assign illegal_instr = rst_n & illegal_q;
    assign state_dbg     = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32 subset executed by the datapath ALU (ADDI, SLL, BNE, JAL, JALR, LUI, LBU, SB).
- It is the producer side of the ALU interface: it drives the 3-bit ALU control code and the operand-mux selects, and it consumes the ALU Zero flag.
- It sequences instruction fetch, decode, execute, memory and writeback through a request/ready handshake with unified memory.

Parameters:
- DATA_WIDTH, 32, instruction/datapath width (instr port width).
- ALU_CTRL_WIDTH, 3, width of alu_control.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  DATA_WIDTH  instruction register contents (valid from DECODE onward).
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_control  out  3  000 add, 001 ne, 010 jal-add, 011 jalr-add, 100 lui, 101 lbu, 110 sb-add, 111 sll.
- src_a_sel  out  2  00 PC, 01 oldPC, 10 rs1.
- src_b_sel  out  2  00 rs2, 01 imm, 10 const 4.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- result_src  out  2  00 ALUOut reg, 01 mem data, 10 ALU result direct.
- pc_src  out  1  0 ALU result, 1 ALUOut reg.
- addr_src  out  1  memory address: 0 PC, 1 ALUOut.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  store qualifier, valid only while mem_req=1.
- ir_write, pc_write, reg_write  out  1 each  write strobes.
- illegal_instr  out  1  sticky unsupported-instruction flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: asynchronous; state becomes FETCH. While rst_n=0, every strobe is 0 (mem_req, mem_we, ir_write, pc_write, reg_write), illegal_instr=0, and all selects and alu_control are 0. Reset in mid-operation abandons the instruction with no partial writes.
- Outputs are Moore, decoded from state. Exceptions: ir_write and pc_write in FETCH are gated by mem_ready. pc_write in BRANCH is !zero.
- FETCH: mem_req=1, addr_src=0, A=PC, B=4, alu=000, pc_src=0. Stay in FETCH while mem_ready=0. On mem_ready: ir_write=1, pc_write=1, go to DECODE.
- DECODE: A=oldPC, B=imm, alu=000, imm_src per opcode (B for BNE, J for JAL). ALUOut captures the branch/jump target.
  - Next state by opcode: 0010011/f3=000 -> EXEC_I; 0110011/f3=001/f7=0 -> EXEC_R; 0110111 -> EXEC_LUI; 0000011/f3=100 and 0100011/f3=000 -> MEM_ADDR; 1100011/f3=001 -> BRANCH; 1101111 -> JAL; 1100111/f3=000 -> JALR_ADDR.
  - Any other encoding -> TRAP.
- EXEC_I: A=rs1, B=imm(I), alu=000. EXEC_R: A=rs1, B=rs2, alu=111. EXEC_LUI: B=imm(U), alu=100. All three go to WB_ALU.
- WB_ALU: result_src=00, reg_write=1, then FETCH.
- MEM_ADDR: A=rs1, B=imm (I for load, S for store), alu=000 -> MEM_RD or MEM_WR.
- MEM_RD: mem_req=1, addr_src=1, mem_we=0. Wait for mem_ready, then go to WB_MEM.
- WB_MEM: result_src=01, alu=101 (zero-extend byte), reg_write=1, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_src=1, alu=110. On mem_ready go to FETCH.
- BRANCH: A=rs1, B=rs2, alu=001, pc_src=1, pc_write=!zero (taken when operands differ), then FETCH.
- JAL: A=oldPC, B=4, alu=010, result_src=10, reg_write=1, pc_src=1, pc_write=1, then FETCH.
- JALR_ADDR: A=rs1, B=imm(I), alu=011 -> JALR_LINK. JALR_LINK: same as JAL.
- TRAP: illegal_instr=1, no strobes. Remains in TRAP until reset.
- Latency with zero-wait memory (mem_ready tied 1): ADDI/SLL/LUI 4 cycles, LBU 5, SB 4, BNE 3, JAL 3, JALR 4. Each mem_ready=0 cycle adds one cycle.
- mem_req stays asserted with a stable address select while waiting. mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC_I, EXEC_R, EXEC_LUI, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, JALR_ADDR, JALR_LINK, TRAP);
  - opcode and funct3 localparams;
  - alu_control codes;
  - src_a/src_b/imm_src/result_src encodings.
- One sub-module, instr_class_decode: combinational instr -> instruction class and legal flag. It is used by DECODE for the next-state choice and for imm_src.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready=1 -> states FETCH,DECODE,EXEC_I,WB_ALU; alu=000, B=imm; reg_write=1 only in cycle 4.
- BNE with zero=0, then zero=1 -> BRANCH asserts pc_write=1 with pc_src=1 in the first case; pc_write=0 in the second; both return to FETCH after 3 cycles.
- LBU with mem_ready low 3 cycles in MEM_RD -> mem_req and addr_src=1 held for 4 cycles; WB_MEM has result_src=01, alu=101; total 8 cycles.
- SB then JAL -> MEM_WR has mem_we=1, alu=110. JAL state has alu=010, result_src=10, reg_write=1, pc_write=1.
- Illegal 0xFFFFFFFF -> TRAP, illegal_instr=1 and held; no strobes for 20 cycles.
- rst_n low mid-MEM_RD -> mem_req drops immediately (async); after release, FETCH with illegal_instr=0.
